aes_decrypt_ctrl: RTL and testbench

Iterative AES-128 decryption sequencer. It accepts one ciphertext block per transaction and runs the initial AddRoundKey (key 10) itself. It then drives an external single-round datapath for rounds 9..1 (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) and an external final-round datapath (no InvMixColumns) for round 0. Round keys come from a key-store read port addressed by this block. The result is returned through a valid/ready output handshake.

---
 rtl/aes_decrypt_ctrl_pkg.sv | 90 +++++++++
 rtl/aes_decrypt_ctrl_final_round.sv | 25 ++
 rtl/aes_decrypt_ctrl.sv | 117 +++++++++++
 tb/tb_aes_decrypt_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_decrypt_ctrl_pkg.sv
// Shared constants, FSM encoding and AES inverse-cipher byte/column helpers
// used by the decryption sequencer and the round datapaths beside it.
package aes_decrypt_ctrl_pkg;

  localparam int DW        = 128;
  localparam int NR        = 10;
  localparam int KEY_IDX_W = 4;

  localparam logic [KEY_IDX_W-1:0] KEY_IDX_NR    = KEY_IDX_W'(NR);
  localparam logic [KEY_IDX_W-1:0] KEY_IDX_FIRST = KEY_IDX_W'(NR - 1);
  localparam logic [KEY_IDX_W-1:0] KEY_IDX_ONE   = KEY_IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // State byte i sits at bits [DW-1-8i -: 8]; byte i is row i%4, column i/4.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul4(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  function automatic logic [DW-1:0] inv_shift_rows(input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[DW-1-8*(rw+4*c) -: 8] = s[DW-1-8*(rw+4*((c-rw+4)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] inv_sub_bytes(input logic [DW-1:0] s);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[DW-1-8*i -: 8] = INV_SBOX[s[DW-1-8*i -: 8]];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] inv_mix_columns(input logic [DW-1:0] s);
    logic [DW-1:0] r;
    logic [7:0]    a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[DW-1-32*c -: 8];
      a1 = s[DW-9-32*c -: 8];
      a2 = s[DW-17-32*c -: 8];
      a3 = s[DW-25-32*c -: 8];
      r[DW-1-32*c  -: 8] = gf_mul4(a0, 4'd14) ^ gf_mul4(a1, 4'd11) ^ gf_mul4(a2, 4'd13) ^ gf_mul4(a3, 4'd9);
      r[DW-9-32*c  -: 8] = gf_mul4(a0, 4'd9)  ^ gf_mul4(a1, 4'd14) ^ gf_mul4(a2, 4'd11) ^ gf_mul4(a3, 4'd13);
      r[DW-17-32*c -: 8] = gf_mul4(a0, 4'd13) ^ gf_mul4(a1, 4'd9)  ^ gf_mul4(a2, 4'd14) ^ gf_mul4(a3, 4'd11);
      r[DW-25-32*c -: 8] = gf_mul4(a0, 4'd11) ^ gf_mul4(a1, 4'd13) ^ gf_mul4(a2, 4'd9)  ^ gf_mul4(a3, 4'd14);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_decrypt_ctrl_final_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, and
// InvMixColumns only when FULL_ROUND is set (the last round omits it).
module aes_decrypt_ctrl_final_round
  import aes_decrypt_ctrl_pkg::*;
#(
  parameter bit FULL_ROUND = 1'b0
) (
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] key_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] ark;

  assign ark = inv_sub_bytes(inv_shift_rows(data_i)) ^ key_i;

  generate
    if (FULL_ROUND) begin : g_full
      assign data_o = inv_mix_columns(ark);
    end else begin : g_final
      assign data_o = ark;
    end
  endgenerate

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES-128 decryption sequencer: applies key 10 itself, then steps
// the external round datapaths through keys 9..0 and hands out the plaintext.
module aes_decrypt_ctrl
  import aes_decrypt_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DW-1:0]        in_data_i,
  output logic [KEY_IDX_W-1:0] key_idx_o,
  input  logic [DW-1:0]        key_i,
  output logic [DW-1:0]        round_data_o,
  output logic [DW-1:0]        round_key_o,
  input  logic [DW-1:0]        round_data_i,
  input  logic [DW-1:0]        final_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DW-1:0]        out_data_o,
  output logic                 busy_o,
  output logic [KEY_IDX_W-1:0] round_o
);

  state_e               state_q, state_d;
  logic [DW-1:0]        data_q, data_d;
  logic [KEY_IDX_W-1:0] cnt_q, cnt_d;
  logic [KEY_IDX_W-1:0] key_idx_q, key_idx_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 in_ready;
  logic                 accept;

  // A finished block can be drained and a new one loaded on the same edge.
  assign in_ready = !clear_i &&
                    ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
  assign accept   = in_valid_i && in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = ROUND;
            data_d  = in_data_i ^ key_i;
            cnt_d   = KEY_IDX_FIRST;
          end
        end
        ROUND: begin
          data_d = round_data_i;
          cnt_d  = cnt_q - KEY_IDX_ONE;
          if (cnt_q == KEY_IDX_ONE) begin
            state_d = FINAL;
          end
        end
        FINAL: begin
          data_d  = final_data_i;
          state_d = DONE;
        end
        DONE: begin
          if (accept) begin
            state_d = ROUND;
            data_d  = in_data_i ^ key_i;
            cnt_d   = KEY_IDX_FIRST;
          end else if (out_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status outputs are registered from the next state.
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == ROUND) || (state_d == FINAL);
    case (state_d)
      ROUND:   key_idx_d = cnt_d;
      FINAL:   key_idx_d = '0;
      default: key_idx_d = KEY_IDX_NR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      key_idx_q   <= KEY_IDX_NR;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      key_idx_q   <= key_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o   = in_ready;
  assign key_idx_o    = key_idx_q;
  assign round_data_o = data_q;
  assign round_key_o  = key_i;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_valid_q ? data_q : '0;
  assign busy_o       = busy_q;
  assign round_o      = cnt_q;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Bench for aes_decrypt_ctrl: results are checked by re-encrypting them with
// a forward AES-128 model and comparing against the ciphertext that was sent.
module tb_aes_decrypt_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         clear_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         out_ready_i = 1'b0;
  logic [127:0] in_data_i = '0;
  logic         in_ready_o, out_valid_o, busy_o;
  logic [127:0] key_i, round_data_o, round_key_o, round_data_i, final_data_i, out_data_o;
  logic [3:0]   key_idx_o, round_o;

  logic [127:0] rk [0:10];
  logic [7:0]   sbox [256];
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 CLK = ~CLK;

  assign key_i = (key_idx_o <= 4'd10) ? rk[key_idx_o] : '0;

  aes_decrypt_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .key_idx_o(key_idx_o), .key_i(key_i),
    .round_data_o(round_data_o), .round_key_o(round_key_o),
    .round_data_i(round_data_i), .final_data_i(final_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .round_o(round_o)
  );

  aes_decrypt_ctrl_final_round #(.FULL_ROUND(1'b1)) u_round (
    .data_i(round_data_o), .key_i(round_key_o), .data_o(round_data_i));
  aes_decrypt_ctrl_final_round #(.FULL_ROUND(1'b0)) u_final (
    .data_i(round_data_o), .key_i(round_key_o), .data_o(final_data_i));

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- forward AES-128 reference ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   b0, b1, b2, b3;
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[rw+4*c] = a[rw+4*((c+rw)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          b0 = t[4*c]; b1 = t[4*c+1]; b2 = t[4*c+2]; b3 = t[4*c+3];
          t[4*c]   = gmul(b0, 8'h02) ^ gmul(b1, 8'h03) ^ b2 ^ b3;
          t[4*c+1] = b0 ^ gmul(b1, 8'h02) ^ gmul(b2, 8'h03) ^ b3;
          t[4*c+2] = b0 ^ b1 ^ gmul(b2, 8'h02) ^ gmul(b3, 8'h03);
          t[4*c+3] = gmul(b0, 8'h03) ^ b1 ^ b2 ^ gmul(b3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i];
      s = s ^ rk[r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (drive at negedge, sample 1ns later) ----------------
  task automatic send(input logic [127:0] ct);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge CLK);
      in_valid_i = 1'b1; in_data_i = ct; out_ready_i = 1'b0;
      #1;
      acc = in_ready_o;
      n++;
    end
    chk("accept", 128'(acc), 128'(1));
  endtask

  task automatic wait_out(input bit noisy, output int lat, output int bad);
    int i;
    i = 0; lat = 0; bad = 0;
    while (lat == 0 && i < 30) begin
      @(negedge CLK);
      i++;
      in_valid_i  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) in_data_i = rand128();
      out_ready_i = 1'b0;
      #1;
      if (out_valid_o) lat = i;
      else if (in_ready_o) bad++;
    end
  endtask

  task automatic handshake();
    @(negedge CLK);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    #1;
    @(negedge CLK);
    out_ready_i = 1'b0;
    #1;
    chk("valid_drop", 128'(out_valid_o), 128'(0));
  endtask

  task automatic do_block(input logic [127:0] ct, input bit noisy, output logic [127:0] res);
    int lat, bad;
    send(ct);
    wait_out(noisy, lat, bad);
    chk("latency", 128'(lat), 128'(11));
    if (noisy) chk("ignored_input", 128'(bad), 128'(0));
    res = out_data_o;
    chk("decrypt", aes_enc(res), ct);
    handshake();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ready"}, 128'(in_ready_o), 128'(1));
    chk({pfx, "_valid"}, 128'(out_valid_o), 128'(0));
    chk({pfx, "_busy"},  128'(busy_o), 128'(0));
    chk({pfx, "_data"},  out_data_o, 128'(0));
    chk({pfx, "_kidx"},  128'(key_idx_o), 128'(10));
    chk({pfx, "_round"}, 128'(round_o), 128'(0));
    chk({pfx, "_state"}, round_data_o, 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] ct, res, r1, r2, d_a;
    int lat, bad, nb, first, nv, n;
    bit found;

    build_sbox();
    set_key(FIPS_KEY);

    // reset state
    repeat (2) @(negedge CLK);
    #1;
    check_reset_outputs("rst");
    @(negedge CLK);
    RST_N = 1'b1;

    // FIPS-197 C.1 with key index trace, busy length and latency
    send(FIPS_CT);
    chk("kidx_0", 128'(key_idx_o), 128'(10));
    nb = 0; first = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge CLK);
      in_valid_i = 1'b0;
      #1;
      if (i <= 10) chk($sformatf("kidx_%0d", i), 128'(key_idx_o), 128'(10 - i));
      if (busy_o) nb++;
      if (out_valid_o && first == 0) first = i;
    end
    chk("busy_cycles", 128'(nb), 128'(10));
    chk("fips_latency", 128'(first), 128'(11));
    chk("fips_pt", out_data_o, FIPS_PT);
    chk("fips_model", aes_enc(out_data_o), FIPS_CT);
    handshake();

    // backpressure then back-to-back all-zero block
    ct = rand128();
    send(ct);
    wait_out(1'b0, lat, bad);
    chk("bp_latency", 128'(lat), 128'(11));
    d_a = out_data_o;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      in_valid_i = 1'b1; in_data_i = '0; out_ready_i = 1'b0;
      #1;
      chk("bp_valid", 128'(out_valid_o), 128'(1));
      chk("bp_data", out_data_o, d_a);
      chk("bp_ready", 128'(in_ready_o), 128'(0));
    end
    @(negedge CLK);
    out_ready_i = 1'b1; in_valid_i = 1'b1; in_data_i = '0;
    #1;
    chk("b2b_ready", 128'(in_ready_o), 128'(1));
    chk("bp_decrypt", aes_enc(d_a), ct);
    wait_out(1'b0, lat, bad);
    chk("b2b_latency", 128'(lat), 128'(11));
    chk("b2b_zero", aes_enc(out_data_o), 128'(0));
    handshake();

    // clear at round 5
    set_key(rand128());
    ct = rand128();
    send(ct);
    found = 1'b0; n = 0;
    while (!found && n < 20) begin
      @(negedge CLK);
      in_valid_i = 1'b0;
      #1;
      n++;
      if (round_o == 4'd5) found = 1'b1;
    end
    chk("clr_round5", 128'(found), 128'(1));
    clear_i = 1'b1;
    @(negedge CLK);
    clear_i = 1'b0;
    #1;
    check_reset_outputs("clr");
    nv = 0;
    repeat (15) begin
      @(negedge CLK);
      #1;
      if (out_valid_o) nv++;
    end
    chk("clr_no_output", 128'(nv), 128'(0));
    @(negedge CLK);
    clear_i = 1'b1; in_valid_i = 1'b1; in_data_i = ct;
    #1;
    chk("clr_blocks_ready", 128'(in_ready_o), 128'(0));
    @(negedge CLK);
    clear_i = 1'b0; in_valid_i = 1'b0;
    #1;
    chk("clr_not_accepted", 128'(busy_o), 128'(0));
    do_block(ct, 1'b0, res);

    // asynchronous reset mid-round
    ct = rand128();
    send(ct);
    repeat (4) begin
      @(negedge CLK);
      in_valid_i = 1'b0;
    end
    #3 RST_N = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("arst_release_ready", 128'(in_ready_o), 128'(1));
    nv = 0;
    repeat (12) begin
      @(negedge CLK);
      #1;
      if (out_valid_o || busy_o) nv++;
    end
    chk("arst_no_output", 128'(nv), 128'(0));
    do_block(rand128(), 1'b0, res);

    // input toggling during rounds must not change the result
    set_key(rand128());
    ct = rand128();
    do_block(ct, 1'b0, r1);
    do_block(ct, 1'b1, r2);
    chk("noisy_same", r2, r1);

    // randomized keys and blocks
    for (int i = 0; i < 6; i++) begin
      set_key(rand128());
      do_block(rand128(), 1'(i % 2), res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
